header_word_tx: RTL and testbench

HEADER_WORD_TX -- requirements
Module: header_word_tx

---
 rtl/header_word_tx.sv | 148 ++++++++++++++
 tb/tb_header_word_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/header_word_tx.sv
// header_word_tx: sends a 512-bit block header as sixteen 32-bit words to a
// downstream word FIFO. Word 0 (bits [511:480]) goes first. After each block
// the module waits IDLE_GAP idle cycles before it accepts the next header.
//
// Ports:
//   clk_wr       write-domain clock; all logic runs on its rising edge
//   rst          asynchronous, active-high reset
//   hdr_valid    upstream offers a header
//   hdr_data     512-bit header; it is sampled only on the capture edge
//   hdr_ready    registered; high while idle and able to accept a header
//   fifo_full    downstream backpressure; a word is issued only when it is 0
//   wr_en        registered word write strobe
//   data_out     registered word; valid when wr_en=1, holds otherwise
//   busy         registered; high in any state other than IDLE
//   blocks_sent  16-bit count of fully sent blocks; wraps from 0xFFFF to 0
//   nonce_iters  (NONCE_SWEEP_EN only) number of repetitions, where 0 means 1
//
// Build option: define NONCE_SWEEP_EN to send each header nonce_iters times.
// Before each resend, word 15 is incremented by 1.
module header_word_tx #(
  parameter int unsigned IDLE_GAP = 2
) (
  input  logic         clk_wr,
  input  logic         rst,
  input  logic         hdr_valid,
  input  logic [511:0] hdr_data,
`ifdef NONCE_SWEEP_EN
  input  logic [31:0]  nonce_iters,
`endif
  output logic         hdr_ready,
  input  logic         fifo_full,
  output logic         wr_en,
  output logic [31:0]  data_out,
  output logic         busy,
  output logic [15:0]  blocks_sent
);

  localparam int unsigned HDR_W  = 512;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned GAP_W  = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state;
  logic [HDR_W-1:0]   hdr_q;
  logic [IDX_W-1:0]   idx;
  logic [GAP_W-1:0]   gap_cnt;
  logic               more_reps;
  logic [HDR_W-1:0]   hdr_rot;
  logic [HDR_W-1:0]   hdr_rot_inc;

  // The header is rotated one word per issue, so the current word is always
  // in the top slot. After 16 issues the original order is restored.
  assign hdr_rot     = {hdr_q[HDR_W-WORD_W-1:0], hdr_q[HDR_W-1 -: WORD_W]};
  assign hdr_rot_inc = {hdr_q[HDR_W-WORD_W-1:0], hdr_q[HDR_W-1 -: WORD_W] + WORD_W'(1)};

`ifdef NONCE_SWEEP_EN
  logic [31:0] reps_left;
  assign more_reps = (reps_left > 32'd1);
`else
  assign more_reps = 1'b0;
`endif

  // Sequencer: capture, word issue under backpressure, gap, repeat
  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hdr_q       <= '0;
      idx         <= '0;
      gap_cnt     <= '0;
      hdr_ready   <= 1'b0;
      wr_en       <= 1'b0;
      data_out    <= '0;
      busy        <= 1'b0;
      blocks_sent <= '0;
`ifdef NONCE_SWEEP_EN
      reps_left   <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          hdr_ready <= 1'b1;
          busy      <= 1'b0;
          if (hdr_valid && hdr_ready) begin
            hdr_q     <= hdr_data;
            idx       <= '0;
            state     <= SEND;
            hdr_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef NONCE_SWEEP_EN
            reps_left <= (nonce_iters == 32'd0) ? 32'd1 : nonce_iters;
`endif
          end
        end

        SEND: begin
          if (!fifo_full) begin
            wr_en    <= 1'b1;
            data_out <= hdr_q[HDR_W-1 -: WORD_W];
            idx      <= idx + IDX_W'(1);
            if (idx == IDX_W'(15)) begin
              // The last word goes out; idx wraps to 0 for any resend.
              blocks_sent <= blocks_sent + 16'd1;
              hdr_q       <= more_reps ? hdr_rot_inc : hdr_rot;
              gap_cnt     <= '0;
              if (IDLE_GAP != 0) begin
                state <= GAP;
              end else if (more_reps) begin
`ifdef NONCE_SWEEP_EN
                reps_left <= reps_left - 32'd1;
`endif
                state <= SEND;
              end else begin
                state     <= IDLE;
                hdr_ready <= 1'b1;
                busy      <= 1'b0;
              end
            end else begin
              hdr_q <= hdr_rot;
            end
          end
        end

        GAP: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
          if (gap_cnt == GAP_W'(IDLE_GAP - 1)) begin
            if (more_reps) begin
`ifdef NONCE_SWEEP_EN
              reps_left <= reps_left - 32'd1;
`endif
              idx   <= '0;
              state <= SEND;
            end else begin
              state     <= IDLE;
              hdr_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_header_word_tx.sv
// Self-checking bench for header_word_tx. The reference model expands each
// accepted header into its expected word stream, including nonce
// repetitions. A monitor collects every word actually written, and the two
// streams are compared.
module tb_header_word_tx;

  localparam int unsigned GAP = 2;

  logic         clk_wr;
  logic         rst;
  logic         hdr_valid;
  logic [511:0] hdr_data;
  logic         hdr_ready;
  logic         fifo_full;
  logic         wr_en;
  logic [31:0]  data_out;
  logic         busy;
  logic [15:0]  blocks_sent;
`ifdef NONCE_SWEEP_EN
  logic [31:0]  nonce_iters;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [15:0] exp_blocks;

  header_word_tx #(.IDLE_GAP(GAP)) dut (
    .clk_wr     (clk_wr),
    .rst        (rst),
    .hdr_valid  (hdr_valid),
    .hdr_data   (hdr_data),
`ifdef NONCE_SWEEP_EN
    .nonce_iters(nonce_iters),
`endif
    .hdr_ready  (hdr_ready),
    .fifo_full  (fifo_full),
    .wr_en      (wr_en),
    .data_out   (data_out),
    .busy       (busy),
    .blocks_sent(blocks_sent)
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [511:0] rand_hdr();
    logic [511:0] h;
    for (int i = 0; i < 16; i++) h[32*i +: 32] = $urandom();
    return h;
  endfunction

  // Monitor: collect written words. A write must never happen on an edge
  // where fifo_full was high, and data_out must hold when no word is written.
  logic [31:0] last_data = '0;
  always @(posedge clk_wr) begin
    logic ff;
    ff = fifo_full;
    #1;
    if (rst) begin
      last_data = '0;
    end else if (wr_en) begin
      check("write_while_full", 32'(ff), 32'd0);
      got_q.push_back(data_out);
      last_data = data_out;
    end else begin
      check("data_out_hold", data_out, last_data);
    end
  end

  // Advance one clock. If a handshake happens on this edge, the model first
  // expands the header into its expected words.
  task automatic tick();
    int reps;
    logic [31:0] w;
    if (hdr_valid && hdr_ready && !rst) begin
      reps = 1;
`ifdef NONCE_SWEEP_EN
      reps = (nonce_iters == 0) ? 1 : int'(nonce_iters);
`endif
      for (int r = 0; r < reps; r++)
        for (int i = 0; i < 16; i++) begin
          w = hdr_data[511-32*i -: 32];
          if (i == 15) w = w + 32'(r);
          exp_q.push_back(w);
        end
      exp_blocks = exp_blocks + 16'(reps);
    end
    @(posedge clk_wr);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    hdr_valid = 1'b0;
    while (!hdr_ready && n < 3000) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    fifo_full = 1'b0;
    check("idle_reached", 32'(hdr_ready), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic compare_streams();
    int n;
    check("word_count", 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("word", got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    check("blocks_sent", 32'(blocks_sent), 32'(exp_blocks));
  endtask

  initial begin
    logic [511:0] h;
    int n;
    rst        = 1'b1;
    hdr_valid  = 1'b0;
    hdr_data   = '0;
    fifo_full  = 1'b0;
    exp_blocks = '0;
`ifdef NONCE_SWEEP_EN
    nonce_iters = 32'd1;
`endif
    repeat (2) @(posedge clk_wr);
    #1;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_hdr_ready", 32'(hdr_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_blocks", 32'(blocks_sent), 32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(hdr_ready), 32'd1);

    // Directed latency case: words i+1 and no backpressure
    for (int i = 0; i < 16; i++) h[511-32*i -: 32] = 32'(i + 1);
    hdr_data  = h;
    hdr_valid = 1'b1;
    tick();
    hdr_valid = 1'b0;
    check("cap_wr_en", 32'(wr_en), 32'd0);
    check("cap_ready", 32'(hdr_ready), 32'd0);
    check("cap_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      hdr_data = rand_hdr();
      tick();
      check("lat_wr_en", 32'(wr_en), 32'd1);
      check("lat_data", data_out, 32'(k));
    end
    for (int g = 1; g <= int'(GAP); g++) begin
      tick();
      check("gap_wr_en", 32'(wr_en), 32'd0);
      check("gap_ready", 32'(hdr_ready), 32'(g == int'(GAP)));
    end
    compare_streams();

    // Reset after word 7: the block is abandoned and the counter is cleared
    hdr_data  = rand_hdr();
    hdr_valid = 1'b1;
    tick();
    hdr_valid = 1'b0;
    n = 0;
    while (got_q.size() < 7 && n < 50) begin
      tick();
      n++;
    end
    check("seven_words", 32'(got_q.size()), 32'd7);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_data", data_out, 32'd0);
    check("mid_rst_blocks", 32'(blocks_sent), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(hdr_ready), 32'd0);
    for (int i = 0; i < 7 && i < got_q.size(); i++) check("partial_word", got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    exp_blocks = '0;
    @(posedge clk_wr);
    #3 rst = 1'b0;
    @(posedge clk_wr);
    #1;
    check("ready_after_mid_rst", 32'(hdr_ready), 32'd1);

    // Randomized traffic: valid toggles, header data changes every cycle,
    // and backpressure is random.
    for (int c = 0; c < 1500; c++) begin
      hdr_valid = ($urandom_range(0, 1) == 1);
      hdr_data  = rand_hdr();
      fifo_full = ($urandom_range(0, 9) < 3);
`ifdef NONCE_SWEEP_EN
      nonce_iters = 32'($urandom_range(0, 3));
`endif
      tick();
    end
    wait_idle();
    compare_streams();

`ifdef NONCE_SWEEP_EN
    // Nonce sweep: word 15 wraps from 0xFFFFFFFF to 0 and then to 1
    h = rand_hdr();
    h[31:0] = 32'hFFFF_FFFF;
    hdr_data    = h;
    nonce_iters = 32'd3;
    hdr_valid   = 1'b1;
    tick();
    hdr_valid = 1'b0;
    hdr_data  = rand_hdr();
    wait_idle();
    compare_streams();
    // nonce_iters=0 sends exactly one block
    hdr_data    = rand_hdr();
    nonce_iters = 32'd0;
    hdr_valid   = 1'b1;
    tick();
    hdr_valid = 1'b0;
    wait_idle();
    compare_streams();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
